// File: rtl/dlatch_bank_ctrl_if.sv
// Requester-side bus of the latch bank write sequencer.
// Level requests in; grant/busy/done/err status back out.
interface dlatch_bank_ctrl_if #(
  parameter int NREQ = 2,
  parameter int AW   = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_data;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output req, req_addr, req_data,
    input  grant, busy, done, err
  );

  modport slave (
    input  req, req_addr, req_data,
    output grant, busy, done, err
  );
endinterface

// File: rtl/dlatch_bank_ctrl.sv
// Round-robin write sequencer for a bank of NOR D-latches.
// Drives data, a timed gate pulse, then checks Q/notQ readback.
module dlatch_bank_ctrl #(
  parameter int NREQ   = 2,
  parameter int NLATCH = 4,
  parameter int AW     = 2,
  parameter int SETUP  = 1,
  parameter int PULSE  = 2,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dlatch_bank_ctrl_if.slave bus,
  output logic              latch_d,
  output logic [NLATCH-1:0] latch_g,
  input  logic [NLATCH-1:0] latch_q,
  input  logic [NLATCH-1:0] latch_qn
);
  localparam int WW = $clog2(NREQ);
  localparam int M1 = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int MC = (M1 > HOLD) ? M1 : HOLD;
  localparam int CW = $clog2(MC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_GATE, S_HOLD, S_CHECK
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [AW-1:0]     addr, addr_n;
  logic [WW-1:0]     last, last_n;
  logic [NREQ-1:0]   grant, grant_n;
  logic              busy, busy_n;
  logic              done, done_n;
  logic              err, err_n;
  logic              d_n;
  logic [NLATCH-1:0] g_n;

  logic [WW-1:0]     win;
  logic              win_vld;
  logic [NLATCH-1:0] dec;
  logic              q_s, qn_s, legal;

  // Scan from last winner + 1 downward so the nearest set bit wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req[(int'(last) + k) % NREQ]) begin
        win_vld = 1'b1;
        win     = WW'((int'(last) + k) % NREQ);
      end
    end
  end

  always_comb begin
    dec  = '0;
    q_s  = 1'b0;
    qn_s = 1'b0;
    for (int i = 0; i < NLATCH; i++) begin
      if (addr == AW'(i)) begin
        dec[i] = 1'b1;
        q_s    = latch_q[i];
        qn_s   = latch_qn[i];
      end
    end
    legal = |dec;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    last_n  = last;
    grant_n = '0;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    d_n     = latch_d;
    g_n     = '0;
    unique case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (win_vld) begin
          grant_n[win] = 1'b1;
          busy_n       = 1'b1;
          addr_n       = bus.req_addr[int'(win)*AW +: AW];
          d_n          = bus.req_data[win];
          last_n       = win;
          cnt_n        = '0;
          state_n      = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == CW'(SETUP - 1)) begin
          cnt_n   = '0;
          state_n = S_GATE;
        end else cnt_n = cnt + 1'b1;
      end
      S_GATE: begin
        g_n = dec;
        if (cnt == CW'(PULSE - 1)) begin
          cnt_n   = '0;
          state_n = S_HOLD;
        end else cnt_n = cnt + 1'b1;
      end
      S_HOLD: begin
        if (cnt == CW'(HOLD - 1)) begin
          cnt_n   = '0;
          state_n = S_CHECK;
        end else cnt_n = cnt + 1'b1;
      end
      S_CHECK: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        err_n   = !legal || (q_s != latch_d) ||
                  (qn_s != ~latch_d);
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr    <= '0;
      last    <= WW'(NREQ - 1);
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      latch_d <= 1'b0;
      latch_g <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr    <= addr_n;
      last    <= last_n;
      grant   <= grant_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
      latch_d <= d_n;
      latch_g <= g_n;
    end
  end

  assign bus.grant = grant;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.err   = err;
endmodule

// File: tb/tb_dlatch_bank_ctrl.sv
// Randomised bench: two banks (4 and 3 latches) share one stimulus.
// A transaction-level model predicts grants, gate window and err.
module tb_dlatch_bank_ctrl;
  localparam int NREQ = 2;
  localparam int AW   = 2;
  localparam int S    = 1;
  localparam int P    = 2;
  localparam int H    = 1;
  localparam int L    = S + P + H + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]    req_data = '0;
  logic [3:0]         stuck = '0;
  logic [3:0]         flip = '0;

  int checks = 0;
  int failures = 0;
  int last = NREQ - 1;

  dlatch_bank_ctrl_if #(.NREQ(NREQ), .AW(AW)) bus_a ();
  dlatch_bank_ctrl_if #(.NREQ(NREQ), .AW(AW)) bus_b ();

  assign bus_a.req      = req;
  assign bus_a.req_addr = req_addr;
  assign bus_a.req_data = req_data;
  assign bus_b.req      = req;
  assign bus_b.req_addr = req_addr;
  assign bus_b.req_data = req_data;

  logic       d_a, d_b;
  logic [3:0] g_a, q_a, qn_a, mem_a;
  logic [2:0] g_b, q_b, qn_b, mem_b;

  dlatch_bank_ctrl #(.NREQ(NREQ), .NLATCH(4), .AW(AW),
    .SETUP(S), .PULSE(P), .HOLD(H)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
    .latch_d(d_a), .latch_g(g_a),
    .latch_q(q_a), .latch_qn(qn_a)
  );

  dlatch_bank_ctrl #(.NREQ(NREQ), .NLATCH(3), .AW(AW),
    .SETUP(S), .PULSE(P), .HOLD(H)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
    .latch_d(d_b), .latch_g(g_b),
    .latch_q(q_b), .latch_qn(qn_b)
  );

  // Transparent-when-gated latch banks with fault injection.
  always @(g_a or d_a)
    for (int i = 0; i < 4; i++) if (g_a[i]) mem_a[i] = d_a;
  always @(g_b or d_b)
    for (int i = 0; i < 3; i++) if (g_b[i]) mem_b[i] = d_b;

  assign q_a  = mem_a & ~stuck;
  assign qn_a = ~q_a ^ flip;
  assign q_b  = mem_b & ~stuck[2:0];
  assign qn_b = ~q_b ^ flip[2:0];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One write: caller is at a negedge in an IDLE/done cycle with req set.
  task automatic epoch(input bit drop);
    int w;
    logic [AW-1:0] a;
    logic dat, ql, qnl, ea, eb;
    logic [3:0] ga, gb;
    logic [NREQ-1:0] gr;
    w = -1;
    for (int j = 1; j <= NREQ; j++)
      if (w < 0 && req[(last + j) % NREQ]) w = (last + j) % NREQ;
    if (w < 0) begin
      check("no_req", 32'(req), 32'd1);
      return;
    end
    a   = req_addr[w*AW +: AW];
    dat = req_data[w];
    ql  = stuck[a] ? 1'b0 : dat;
    qnl = flip[a] ? ql : ~ql;
    ea  = (ql != dat) || (qnl != ~dat);
    eb  = (a >= 2'd3) || ea;
    last = w;
    gr = '0;
    gr[w] = 1'b1;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      ga = '0;
      gb = '0;
      if (k >= S + 2 && k <= S + P + 1) begin
        ga[a] = 1'b1;
        if (a < 2'd3) gb[a] = 1'b1;
      end
      check("seq_a",
        {gr & {NREQ{k == 1}}, k < L, k == L, ea && k == L, ga},
        {bus_a.grant, bus_a.busy, bus_a.done, bus_a.err, g_a});
      check("seq_b",
        {gr & {NREQ{k == 1}}, k < L, k == L, eb && k == L, gb},
        {bus_b.grant, bus_b.busy, bus_b.done, bus_b.err, 1'b0, g_b});
      check("data_a", 32'(d_a), 32'(dat));
      check("data_b", 32'(d_b), 32'(dat));
      if (k == 1 && drop) req[w] = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_a", {bus_a.grant, bus_a.busy, bus_a.done,
                    bus_a.err, d_a, g_a}, '0);
    check("rst_b", {bus_b.grant, bus_b.busy, bus_b.done,
                    bus_b.err, d_b, g_b}, '0);
    rst_n = 1'b1;

    req = 2'b10;
    req_addr = {2'd1, 2'd0};
    req_data = 2'b10;
    repeat (3) @(negedge clk);
    check("gate_pre_rst", 32'(g_a), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid", {bus_a.busy, g_a, bus_b.busy, g_b}, '0);
    @(negedge clk);
    check("rst_hold", {bus_a.done, bus_a.grant}, '0);
    rst_n = 1'b1;
    last = NREQ - 1;
    epoch(1'b1);

    req = 2'b11;
    req_addr = {2'd1, 2'd0};
    req_data = 2'b10;
    repeat (3) epoch(1'b0);
    req = '0;

    req = 2'b01;
    req_addr = {2'd0, 2'd2};
    req_data = 2'b01;
    epoch(1'b1);

    stuck = 4'b1000;
    req = 2'b01;
    req_addr = {2'd0, 2'd3};
    req_data = 2'b01;
    epoch(1'b1);
    stuck = '0;

    flip = 4'b0100;
    req = 2'b10;
    req_addr = {2'd2, 2'd0};
    req_data = 2'b00;
    epoch(1'b1);
    flip = '0;

    req = 2'b10;
    req_addr = {2'd3, 2'd0};
    req_data = 2'b10;
    epoch(1'b1);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && ($urandom % 2 == 1)) begin
          req[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom);
          req_data[i] = 1'($urandom);
        end
      end
      if (req == '0) begin
        req[0] = 1'b1;
        req_addr[0 +: AW] = AW'($urandom);
        req_data[0] = 1'($urandom);
      end
      stuck = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      flip  = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      epoch(1'b1);
    end
    req = '0;
    @(negedge clk);
    check("idle_end", {bus_a.busy, bus_b.busy, g_a, g_b}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
